// File: rtl/oven_cook_timer.sv
// Cook-time countdown: user-set MM:SS, armed with the oven, counts down after preheat, buzzes when done.
// Optional macro OVEN_TIMER_AUTOREPEAT_EN adds hold-to-repeat on both buttons.
module oven_cook_timer #(
  parameter int CLK_HZ        = 50000000,
  parameter int STEP_SEC      = 30,
  parameter int DEFAULT_MIN   = 10,
  parameter int BUZZ_DIV      = 25000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button1,
  input  logic       button2,
  input  logic       toggle_oven,
  input  logic       toggle_set,
  input  logic       temp_reached,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       timer_reached,
  output logic       buzzer
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [6:0]    STEP      = 7'(STEP_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BUZZ_MAX  = BW'(BUZZ_DIV - 1);

  // Saturating add: a press that would pass 99:59 leaves the time unchanged.
  function automatic logic [12:0] time_inc(input logic [6:0] m, input logic [5:0] s);
    logic [6:0] ss;
    ss = {1'b0, s} + STEP;
    if (ss >= 7'd60) begin
      if (m == 7'd99) return {m, s};
      else return {m + 7'd1, 6'(ss - 7'd60)};
    end else begin
      return {m, ss[5:0]};
    end
  endfunction

  function automatic logic [12:0] time_dec(input logic [6:0] m, input logic [5:0] s);
    if ({1'b0, s} >= STEP) return {m, 6'({1'b0, s} - STEP)};
    else if (m != 7'd0) return {m - 7'd1, 6'({1'b0, s} + 7'd60 - STEP)};
    else return 13'd0;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  logic [1:0]    b1_sync_r, b2_sync_r;
  logic          b1_prev_r, b2_prev_r;
  logic          rpt1_s, rpt2_s, press1_s, press2_s, tick_s, show_rem_s;
  logic [1:0]    state_r, state_nxt_s;
  logic [6:0]    set_min_r, set_min_nxt_s, rem_min_r, rem_min_nxt_s, disp_min_s;
  logic [5:0]    set_sec_r, set_sec_nxt_s, rem_sec_r, rem_sec_nxt_s, disp_sec_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic [BW-1:0] buzz_cnt_r, buzz_cnt_nxt_s;
  logic          buzzer_nxt_s;

  // Two-flop synchronizers plus previous-value flops for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1_sync_r <= 2'b11;
      b2_sync_r <= 2'b11;
      b1_prev_r <= 1'b1;
      b2_prev_r <= 1'b1;
    end else begin
      b1_sync_r <= {b1_sync_r[0], button1};
      b2_sync_r <= {b2_sync_r[0], button2};
      b1_prev_r <= b1_sync_r[1];
      b2_prev_r <= b2_sync_r[1];
    end
  end

`ifdef OVEN_TIMER_AUTOREPEAT_EN
  localparam int CW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
  localparam logic [CW-1:0] RPT_AT     = CW'(HOLD_CYCLES + REPEAT_CYCLES);
  localparam logic [CW-1:0] RPT_RELOAD = CW'(HOLD_CYCLES + 1);
  logic [CW-1:0] h1_cnt_r, h2_cnt_r;

  assign rpt1_s = ~b1_sync_r[1] && (h1_cnt_r == RPT_AT);
  assign rpt2_s = ~b2_sync_r[1] && (h2_cnt_r == RPT_AT);

  // Hold counters count low cycles since the edge; reload keeps the repeat period fixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_cnt_r <= '0;
      h2_cnt_r <= '0;
    end else begin
      if (b1_sync_r[1]) h1_cnt_r <= '0;
      else if (rpt1_s) h1_cnt_r <= RPT_RELOAD;
      else h1_cnt_r <= h1_cnt_r + CW'(1);
      if (b2_sync_r[1]) h2_cnt_r <= '0;
      else if (rpt2_s) h2_cnt_r <= RPT_RELOAD;
      else h2_cnt_r <= h2_cnt_r + CW'(1);
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign rpt1_s = 1'b0;
  assign rpt2_s = 1'b0;
`endif

  assign press1_s = (b1_prev_r & ~b1_sync_r[1]) | rpt1_s;
  assign press2_s = (b2_prev_r & ~b2_sync_r[1]) | rpt2_s;
  assign tick_s   = (state_r == ST_RUN) && (presc_r == PRESC_MAX);

  // Next-state, set-time edits, countdown, prescaler and buzzer divider.
  always_comb begin
    state_nxt_s   = state_r;
    set_min_nxt_s = set_min_r;
    set_sec_nxt_s = set_sec_r;
    rem_min_nxt_s = rem_min_r;
    rem_sec_nxt_s = rem_sec_r;
    case (state_r)
      ST_IDLE: begin
        if (toggle_set && press1_s) {set_min_nxt_s, set_sec_nxt_s} = time_inc(set_min_r, set_sec_r);
        else if (toggle_set && press2_s) {set_min_nxt_s, set_sec_nxt_s} = time_dec(set_min_r, set_sec_r);
        else {set_min_nxt_s, set_sec_nxt_s} = {set_min_r, set_sec_r};
        if (toggle_oven && ({set_min_nxt_s, set_sec_nxt_s} != 13'd0)) state_nxt_s = ST_ARMED;
        else state_nxt_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (!toggle_oven) begin
          state_nxt_s = ST_IDLE;
        end else if (temp_reached) begin
          state_nxt_s   = ST_RUN;
          rem_min_nxt_s = set_min_r;
          rem_sec_nxt_s = set_sec_r;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_RUN: begin
        // Switching off beats a coincident tick or expiry.
        if (!toggle_oven) begin
          state_nxt_s   = ST_IDLE;
          rem_min_nxt_s = 7'd0;
          rem_sec_nxt_s = 6'd0;
        end else if (tick_s) begin
          if (rem_min_r == 7'd0 && rem_sec_r == 6'd1) begin
            state_nxt_s   = ST_DONE;
            rem_sec_nxt_s = 6'd0;
          end else if (rem_sec_r != 6'd0) begin
            rem_sec_nxt_s = rem_sec_r - 6'd1;
          end else begin
            rem_min_nxt_s = rem_min_r - 7'd1;
            rem_sec_nxt_s = 6'd59;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!toggle_oven || press1_s || press2_s) begin
          state_nxt_s   = ST_IDLE;
          rem_min_nxt_s = 7'd0;
          rem_sec_nxt_s = 6'd0;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (state_r == ST_RUN && state_nxt_s == ST_RUN) presc_nxt_s = tick_s ? '0 : presc_r + PW'(1);
    else presc_nxt_s = '0;

    if (state_r == ST_DONE && state_nxt_s == ST_DONE) begin
      if (buzz_cnt_r == BUZZ_MAX) begin
        buzz_cnt_nxt_s = '0;
        buzzer_nxt_s   = ~buzzer;
      end else begin
        buzz_cnt_nxt_s = buzz_cnt_r + BW'(1);
        buzzer_nxt_s   = buzzer;
      end
    end else begin
      buzz_cnt_nxt_s = '0;
      buzzer_nxt_s   = 1'b0;
    end

    show_rem_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DONE);
    disp_min_s = show_rem_s ? rem_min_nxt_s : set_min_nxt_s;
    disp_sec_s = show_rem_s ? rem_sec_nxt_s : set_sec_nxt_s;
  end

  // State, time registers and outputs all load from next-state so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      set_min_r     <= 7'(DEFAULT_MIN);
      set_sec_r     <= 6'd0;
      rem_min_r     <= 7'd0;
      rem_sec_r     <= 6'd0;
      presc_r       <= '0;
      buzz_cnt_r    <= '0;
      buzzer        <= 1'b0;
      running       <= 1'b0;
      timer_reached <= 1'b0;
      min_tens      <= 4'(DEFAULT_MIN / 10);
      min_ones      <= 4'(DEFAULT_MIN % 10);
      sec_tens      <= 4'd0;
      sec_ones      <= 4'd0;
    end else begin
      state_r       <= state_nxt_s;
      set_min_r     <= set_min_nxt_s;
      set_sec_r     <= set_sec_nxt_s;
      rem_min_r     <= rem_min_nxt_s;
      rem_sec_r     <= rem_sec_nxt_s;
      presc_r       <= presc_nxt_s;
      buzz_cnt_r    <= buzz_cnt_nxt_s;
      buzzer        <= buzzer_nxt_s;
      running       <= (state_nxt_s == ST_RUN);
      timer_reached <= (state_nxt_s == ST_DONE);
      {min_tens, min_ones} <= to_bcd(disp_min_s);
      {sec_tens, sec_ones} <= to_bcd({1'b0, disp_sec_s});
    end
  end

endmodule

// File: doc/oven_cook_timer.md
Name: oven_cook_timer

Overview:
- Cook-time countdown stage downstream of the oven temperature controller.
- Consumes the controller's temp_reached flag and the shared button/switch inputs.
- Holds a user-set MM:SS cook time, arms when the oven is switched on, and counts down once preheat is reached.
- Drives BCD digits to the hex display mux, the timer_reached lamp and a buzzer.

Parameters:
- CLK_HZ, 50000000, clk cycles per one-second tick.
- STEP_SEC, 30, seconds added/removed per button press (1..59).
- DEFAULT_MIN, 10, set-time minutes after reset (0..99); seconds reset to 00.
- BUZZ_DIV, 25000, clk cycles per buzzer half-period in DONE.
- HOLD_CYCLES, 25000000, hold time before auto-repeat starts (optional feature only).
- REPEAT_CYCLES, 5000000, auto-repeat period (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- button1  in  1  active-low increase button (raw).
- button2  in  1  active-low decrease button (raw).
- toggle_oven  in  1  S0, 1 = oven on.
- toggle_set  in  1  S2, 1 = buttons edit cook time (0 = temperature, ignored here).
- temp_reached  in  1  preheat-reached flag from the temperature controller.
- min_tens  out  4  BCD.
- min_ones  out  4  BCD.
- sec_tens  out  4  BCD, 0..5.
- sec_ones  out  4  BCD.
- running  out  1  high in RUN.
- timer_reached  out  1  high in DONE.
- buzzer  out  1  square wave in DONE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; set time = DEFAULT_MIN:00; remaining = 00:00.
  - Prescaler and buzzer divider = 0.
  - Outputs: digits show set time (default 1,0,0,0); running = 0, timer_reached = 0, buzzer = 0.
- Button input:
  - Each button goes through a 2-FF synchronizer.
  - A press is the 1->0 edge of the synchronized signal: a one-cycle event, acted on the next clk.
  - button1 takes priority if both press events occur in the same cycle.
- Set-time arithmetic (BCD MM:SS, seconds always 0..59):
  - Increment adds STEP_SEC with carry into minutes. If the result exceeds 99:59, the press is ignored (no change).
  - Decrement subtracts STEP_SEC with borrow. If the result is below 00:00, set time clamps to 00:00.
  - Edits happen only in IDLE with toggle_set = 1.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in RUN, cleared on RUN entry.
  - tick = 1 for the cycle where count = CLK_HZ-1, so the first tick arrives CLK_HZ cycles after RUN entry.
- FSM (registered, one transition per clk):
  - IDLE: if toggle_oven = 1 and set time != 00:00, go to ARMED. If toggle_oven = 1 and set time = 00:00, stay in IDLE.
  - ARMED:
    - toggle_oven = 0 -> IDLE.
    - Else if temp_reached = 1 -> RUN, loading remaining = set time and clearing the prescaler.
    - Buttons are ignored.
  - RUN:
    - Each tick decrements remaining by one second (00 seconds borrows: MM-1:59).
    - A tick taking remaining from 00:01 to 00:00 -> DONE.
    - toggle_oven = 0 -> IDLE; remaining is discarded, set time is kept.
    - toggle_oven = 0 wins over a simultaneous tick or expiry.
    - Buttons are ignored. temp_reached dropping does not pause the count.
  - DONE:
    - buzzer toggles every BUZZ_DIV cycles, starting at 0.
    - toggle_oven = 0 or any button press event -> IDLE, with buzzer forced to 0.
- Display:
  - IDLE/ARMED show set time.
  - RUN/DONE show remaining (00:00 in DONE).
- running and timer_reached are registered decodes of state, valid in the same cycle the state is.

Optional Feature:
- Macro: OVEN_TIMER_AUTOREPEAT_EN.
- Defined: while a synchronized button stays low, after HOLD_CYCLES an additional press event is generated every REPEAT_CYCLES until release. Saturation and clamp rules apply to each event. The hold counter resets on release and on rst.
- Undefined: only edge presses; HOLD_CYCLES and REPEAT_CYCLES are unused, and no hold counter is synthesized.

Test Plan:
- Reset: assert rst mid-clock with no clk edge -> immediately digits 1,0,0,0; running = 0, timer_reached = 0, buzzer = 0.
- Editing: toggle_set = 1, three button1 presses -> 11:30; one button2 press -> 11:00; toggle_set = 0 plus a button1 press -> stays 11:00.
- Bounds:
  - From 00:30, two button2 presses -> 00:00; then toggle_oven = 1 -> stays IDLE, running = 0.
  - From 99:30, a button1 press -> stays 99:30.
- Countdown (CLK_HZ = 10):
  - Set 01:00, toggle_oven = 1, temp_reached = 0 for 50 cycles -> display 01:00, running = 0.
  - temp_reached = 1 -> running = 1; 10 cycles after RUN entry -> 00:59; 600 cycles after RUN entry -> 00:00 with timer_reached = 1.
  - buzzer toggles every BUZZ_DIV cycles; a button2 press -> IDLE, display 01:00.
- Cancel: during RUN at 00:42, toggle_oven = 0 coinciding with a tick -> IDLE next cycle, display 01:00, running = 0, no DONE.
- Auto-repeat (macro defined; HOLD_CYCLES = 20, REPEAT_CYCLES = 5): hold button1 low for 31 cycles from 10:00 -> 11:30 (1 edge + 2 repeats); macro undefined -> 10:30.
